// File: rtl/rv32v_pkg.sv
// Shared types and constants for the RV32V hazard/flush controller.
// Stage bit order used by every stage vector: [0]=f1 [1]=f2 [2]=dec [3]=ex [4]=mem.
package rv32v_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        VEC_BUSY  = 2'd1,
        CSR_DRAIN = 2'd2,
        EXC_FLUSH = 2'd3
    } hazard_state_t;

    // Width of the exception flush hold counter (FLUSH_CYCLES is 1..15).
    localparam int FLUSH_CNT_W = 4;

    localparam int NUM_STAGES = 5;

    // Stage groups used for forced stall/flush terms.
    localparam logic [NUM_STAGES-1:0] MASK_FETCH     = 5'b00011; // f1, f2
    localparam logic [NUM_STAGES-1:0] MASK_FRONT     = 5'b00111; // f1, f2, dec
    localparam logic [NUM_STAGES-1:0] MASK_DEC       = 5'b00100; // dec only
    localparam logic [NUM_STAGES-1:0] MASK_UPTO_EX   = 5'b01111; // f1 .. ex
    localparam logic [NUM_STAGES-1:0] MASK_ALL       = 5'b11111;

endpackage

// File: rtl/rv32v_flush_counter.sv
// Loadable down-counter that saturates at zero. zero_next flags that the
// count is zero, or becomes zero with the current decrement (count <= 1),
// so a state that decrements can leave on the cycle the count runs out.
module rv32v_flush_counter #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero_next
);

    logic [W-1:0] count_reg;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero_next = (count_reg <= W'(1));

endmodule

// File: rtl/rv32v_hazard_unit.sv
// Central stall/flush controller for the RV32V vector pipeline.
// Combinational backpressure chain plus a small FSM covering vector
// occupancy, CSR drain and multi-cycle exception flush.
// Optional build macro RV32V_HAZARD_WDOG_EN adds a vector-busy watchdog
// (parameter WDOG_LIMIT, output wdog_fire).
module rv32v_hazard_unit
    import rv32v_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
`ifdef RV32V_HAZARD_WDOG_EN
    , parameter int WDOG_LIMIT = 1024
`endif
) (
    input  logic CLK,
    input  logic RST,
    input  logic busy_f1,
    input  logic busy_f2,
    input  logic busy_dec,
    input  logic busy_ex,
    input  logic busy_mem,
    input  logic decode_ena,
    input  logic execute_ena,
    input  logic memory_ena,
    input  logic writeback_ena,
    input  logic csr_update,
    input  logic exception_mem,
    input  logic v_busy,
    input  logic v_done,
    output logic stall_f1,
    output logic stall_f2,
    output logic stall_dec,
    output logic stall_ex,
    output logic stall_mem,
    output logic flush_f1,
    output logic flush_f2,
    output logic flush_dec,
    output logic flush_ex,
    output logic flush_mem,
    output logic v_decode_done
`ifdef RV32V_HAZARD_WDOG_EN
    , output logic wdog_fire
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    hazard_state_t state_reg;
    hazard_state_t state_next;
    logic          v_decode_done_reg;
    logic          v_decode_done_next;

    logic [NUM_STAGES-1:0] busy_vec;
    logic [NUM_STAGES-1:0] chain_vec;
    logic [NUM_STAGES-1:0] stall_force;
    logic [NUM_STAGES-1:0] flush_force;
    logic [NUM_STAGES-1:0] stall_vec;
    logic [NUM_STAGES-1:0] flush_vec;

    logic exc_event;
    logic csr_event;
    logic exc_load;
    logic exc_zero_next;
    logic wdog_hit;

    // execute_ena carries no hazard information for this controller; it stays
    // on the port list so the stage-valid interface is uniform.
    logic unused_execute_ena;
    assign unused_execute_ena = execute_ena;

    assign busy_vec = {busy_mem, busy_ex, busy_dec, busy_f2, busy_f1};

    // A stage stalls when it or any stage downstream of it is busy.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_chain
        assign chain_vec[gi] = |busy_vec[NUM_STAGES-1:gi];
    end

`ifdef RV32V_HAZARD_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

    logic wdog_load;
    logic wdog_zero_next;

    // Loaded with the full limit on entry; the limit-th busy cycle sees count 1.
    assign wdog_load = (state_next == VEC_BUSY) && (state_reg != VEC_BUSY);

    rv32v_flush_counter #(.W(WDOG_W)) u_wdog_counter (
        .CLK       (CLK),
        .RST       (RST),
        .load      (wdog_load),
        .dec       (state_reg == VEC_BUSY),
        .load_val  (WDOG_W'(WDOG_LIMIT)),
        .zero_next (wdog_zero_next)
    );

    assign wdog_hit  = (state_reg == VEC_BUSY) && wdog_zero_next;
    assign wdog_fire = wdog_hit && !RST;
`else
    assign wdog_hit = 1'b0;
`endif

    // A watchdog expiry is handled exactly like a memory-stage exception.
    assign exc_event = exception_mem || wdog_hit;
    // CSR writes only matter while the front end is live; in CSR_DRAIN and
    // EXC_FLUSH the memory stage cannot hold a fresh CSR write.
    assign csr_event = csr_update && memory_ena &&
                       ((state_reg == RUN) || (state_reg == VEC_BUSY));

    rv32v_flush_counter #(.W(FLUSH_CNT_W)) u_exc_counter (
        .CLK       (CLK),
        .RST       (RST),
        .load      (exc_load),
        .dec       (state_reg == EXC_FLUSH),
        .load_val  (FLUSH_LOAD),
        .zero_next (exc_zero_next)
    );

    // State register and the one-cycle vector-release pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg         <= RUN;
            v_decode_done_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            v_decode_done_reg <= v_decode_done_next;
        end
    end

    // Next state and forced stall/flush terms, highest-priority event first.
    always_comb begin
        state_next         = state_reg;
        v_decode_done_next = 1'b0;
        exc_load           = 1'b0;
        stall_force        = '0;
        flush_force        = '0;
        if (exc_event) begin
            flush_force = MASK_ALL;
            exc_load    = 1'b1;
            state_next  = EXC_FLUSH;
        end else if (csr_event) begin
            flush_force = MASK_UPTO_EX;
            state_next  = CSR_DRAIN;
        end else begin
            case (state_reg)
                RUN: begin
                    if (decode_ena && v_busy) begin
                        state_next = VEC_BUSY;
                    end
                end
                VEC_BUSY: begin
                    stall_force = MASK_FRONT;
                    if (v_done) begin
                        state_next         = RUN;
                        v_decode_done_next = 1'b1;
                    end
                end
                CSR_DRAIN: begin
                    stall_force = MASK_FETCH;
                    flush_force = MASK_DEC;
                    if (!busy_ex && !busy_mem && !writeback_ena) begin
                        state_next = RUN;
                    end
                end
                EXC_FLUSH: begin
                    flush_force = MASK_FRONT;
                    if (exc_zero_next) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // Reset squashes every stage; otherwise flush wins over stall per stage.
    always_comb begin
        flush_vec = RST ? MASK_ALL : flush_force;
        stall_vec = RST ? '0 : ((chain_vec | stall_force) & ~flush_vec);
    end

    assign {stall_mem, stall_ex, stall_dec, stall_f2, stall_f1} = stall_vec;
    assign {flush_mem, flush_ex, flush_dec, flush_f2, flush_f1} = flush_vec;
    assign v_decode_done = v_decode_done_reg;

endmodule

// File: tb/tb_rv32v_hazard_unit.sv
// Self-checking bench for rv32v_hazard_unit: a hand-written vector table for
// the directed scenarios, reset/watchdog sequences, and a randomized phase
// checked against a behavioural model kept here.
`timescale 1ns/1ps
module tb_rv32v_hazard_unit;

    localparam int FC = 3;
    localparam int WD = 8;

    typedef struct packed {
        logic [4:0] busy;   // [0]=f1 .. [4]=mem
        logic       dec_ena;
        logic       ex_ena;
        logic       mem_ena;
        logic       wb_ena;
        logic       csr;
        logic       exc;
        logic       vbusy;
        logic       vdone;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [4:0] stall;
        logic [4:0] flush;
        logic       vdd;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic busy_f1, busy_f2, busy_dec, busy_ex, busy_mem;
    logic decode_ena, execute_ena, memory_ena, writeback_ena;
    logic csr_update, exception_mem, v_busy, v_done;
    logic stall_f1, stall_f2, stall_dec, stall_ex, stall_mem;
    logic flush_f1, flush_f2, flush_dec, flush_ex, flush_mem;
    logic v_decode_done;
`ifdef RV32V_HAZARD_WDOG_EN
    logic wdog_fire;
`endif

    always #5 CLK = ~CLK;

    rv32v_hazard_unit #(
        .FLUSH_CYCLES(FC)
`ifdef RV32V_HAZARD_WDOG_EN
        , .WDOG_LIMIT(WD)
`endif
    ) dut (
        .CLK(CLK), .RST(RST),
        .busy_f1(busy_f1), .busy_f2(busy_f2), .busy_dec(busy_dec),
        .busy_ex(busy_ex), .busy_mem(busy_mem),
        .decode_ena(decode_ena), .execute_ena(execute_ena),
        .memory_ena(memory_ena), .writeback_ena(writeback_ena),
        .csr_update(csr_update), .exception_mem(exception_mem),
        .v_busy(v_busy), .v_done(v_done),
        .stall_f1(stall_f1), .stall_f2(stall_f2), .stall_dec(stall_dec),
        .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_f1(flush_f1), .flush_f2(flush_f2), .flush_dec(flush_dec),
        .flush_ex(flush_ex), .flush_mem(flush_mem),
        .v_decode_done(v_decode_done)
`ifdef RV32V_HAZARD_WDOG_EN
        , .wdog_fire(wdog_fire)
`endif
    );

    logic [4:0] d_stall, d_flush;
    assign d_stall = {stall_mem, stall_ex, stall_dec, stall_f2, stall_f1};
    assign d_flush = {flush_mem, flush_ex, flush_dec, flush_f2, flush_f1};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic last_fire = 1'b0;

    // Behavioural model: mode 0 idle, 1 vector in flight, 2 CSR drain,
    // 3 exception flush. m_left = flush cycles still to run, m_vcnt = vector
    // cycles already spent, m_vdd = release pulse due this cycle.
    int   m_mode = 0;
    int   m_left = 0;
    int   m_vcnt = 0;
    logic m_vdd  = 1'b0;

    function automatic vec_t mk(input logic [4:0] busy, input logic dec, mem, wb, csr, exc, vb, vd,
                                input logic [4:0] st, fl, input logic vdd);
        vec_t v;
        v = '0;
        v.in.busy = busy; v.in.dec_ena = dec; v.in.mem_ena = mem; v.in.wb_ena = wb;
        v.in.csr = csr; v.in.exc = exc; v.in.vbusy = vb; v.in.vdone = vd;
        v.stall = st; v.flush = fl; v.vdd = vdd;
        return v;
    endfunction

    task automatic chk(input string tag, input string what, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %b expected %b", tag, what, act, exp);
        end
    endtask

    task automatic drive(input in_t vi);
        {busy_mem, busy_ex, busy_dec, busy_f2, busy_f1} = vi.busy;
        decode_ena = vi.dec_ena; execute_ena = vi.ex_ena;
        memory_ena = vi.mem_ena; writeback_ena = vi.wb_ena;
        csr_update = vi.csr; exception_mem = vi.exc;
        v_busy = vi.vbusy; v_done = vi.vdone;
    endtask

    function automatic void model_eval(input in_t i, output logic [4:0] st, output logic [4:0] fl,
                                       output logic wf, output logic exc_ev, output logic csr_ev);
        logic [4:0] s;
        wf = 1'b0;
`ifdef RV32V_HAZARD_WDOG_EN
        wf = (m_mode == 1) && (m_vcnt + 1 == WD);
`endif
        exc_ev = i.exc || wf;
        csr_ev = !exc_ev && i.csr && i.mem_ena && (m_mode <= 1);
        for (int k = 0; k < 5; k++) s[k] = ((i.busy >> k) != 5'd0);
        fl = 5'b00000;
        if (m_mode == 1) s = s | 5'b00111;
        if (m_mode == 2) begin s = s | 5'b00011; fl = fl | 5'b00100; end
        if (m_mode == 3) fl = fl | 5'b00111;
        if (csr_ev) fl = fl | 5'b01111;
        if (exc_ev) fl = 5'b11111;
        st = s & ~fl;
    endfunction

    task automatic model_step(input in_t i, input logic exc_ev, input logic csr_ev);
        m_vdd = 1'b0;
        if (exc_ev) begin
            m_mode = 3;
            m_left = (FC > 1) ? FC - 1 : 1;
        end else if (csr_ev) begin
            m_mode = 2;
        end else begin
            case (m_mode)
                0: if (i.dec_ena && i.vbusy) begin m_mode = 1; m_vcnt = 0; end
                1: begin
                    m_vcnt++;
                    if (i.vdone) begin m_mode = 0; m_vdd = 1'b1; end
                end
                2: if (!i.busy[3] && !i.busy[4] && !i.wb_ena) m_mode = 0;
                default: begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            endcase
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_vcnt = 0; m_vdd = 1'b0;
    endtask

    // One clock of stimulus: drive after the falling edge, sample before the
    // rising edge, then advance the model on the rising edge.
    task automatic do_cycle(input in_t vi, input bit use_tab, input vec_t tv, input string tag);
        logic [4:0] est, efl;
        logic ewf, eexc, ecsr, evdd;
        @(negedge CLK);
        drive(vi);
        #2;
        model_eval(vi, est, efl, ewf, eexc, ecsr);
        evdd = m_vdd;
        if (use_tab) begin
            est = tv.stall; efl = tv.flush; evdd = tv.vdd;
        end
        $display("%s cyc=%0d busy=%b de=%b me=%b wb=%b csr=%b exc=%b vb=%b vd=%b | stall=%b flush=%b vdd=%b",
                 tag, cyc, vi.busy, vi.dec_ena, vi.mem_ena, vi.wb_ena, vi.csr, vi.exc,
                 vi.vbusy, vi.vdone, d_stall, d_flush, v_decode_done);
        chk(tag, "stall", d_stall, est);
        chk(tag, "flush", d_flush, efl);
        chk(tag, "v_decode_done", {4'b0, v_decode_done}, {4'b0, evdd});
`ifdef RV32V_HAZARD_WDOG_EN
        chk(tag, "wdog_fire", {4'b0, wdog_fire}, {4'b0, ewf});
        last_fire = wdog_fire;
`endif
        cyc++;
        @(posedge CLK);
        model_step(vi, eexc, ecsr);
    endtask

    vec_t tab[32];
    in_t  vi;
    vec_t none;

    initial begin
        none = '0;
        //              busy     de me wb cs ex vb vd  stall    flush    vdd
        tab[0]  = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0); // idle after reset
        tab[1]  = mk(5'b01000, 0, 0, 0, 0, 0, 0, 0, 5'b01111, 5'b00000, 0); // busy_ex chain
        tab[2]  = mk(5'b10000, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0); // busy_mem chain
        tab[3]  = mk(5'b00010, 0, 0, 0, 0, 0, 0, 0, 5'b00011, 5'b00000, 0); // busy_f2 chain
        tab[4]  = mk(5'b00000, 1, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 0); // vector enters
        tab[5]  = mk(5'b00000, 0, 0, 0, 0, 0, 1, 0, 5'b00111, 5'b00000, 0);
        tab[6]  = mk(5'b01000, 0, 0, 0, 0, 0, 1, 0, 5'b01111, 5'b00000, 0);
        tab[7]  = mk(5'b00000, 0, 0, 0, 0, 0, 1, 0, 5'b00111, 5'b00000, 0);
        tab[8]  = mk(5'b00000, 0, 0, 0, 0, 0, 1, 0, 5'b00111, 5'b00000, 0);
        tab[9]  = mk(5'b00000, 0, 0, 0, 0, 0, 1, 1, 5'b00111, 5'b00000, 0); // v_done
        tab[10] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1); // release pulse
        tab[11] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 0); // stray v_done
        tab[12] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0); // no pulse
        tab[13] = mk(5'b10000, 0, 1, 0, 1, 0, 0, 0, 5'b10000, 5'b01111, 0); // CSR commit
        tab[14] = mk(5'b10000, 0, 1, 0, 0, 0, 0, 0, 5'b11011, 5'b00100, 0);
        tab[15] = mk(5'b10000, 0, 1, 0, 0, 0, 0, 0, 5'b11011, 5'b00100, 0);
        tab[16] = mk(5'b10000, 0, 1, 0, 0, 0, 0, 0, 5'b11011, 5'b00100, 0);
        tab[17] = mk(5'b00000, 0, 0, 1, 0, 0, 0, 0, 5'b00011, 5'b00100, 0); // wb still valid
        tab[18] = mk(5'b00000, 0, 1, 0, 1, 0, 0, 0, 5'b00011, 5'b00100, 0); // drained, csr ignored
        tab[19] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        tab[20] = mk(5'b00000, 1, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 0); // vector enters
        tab[21] = mk(5'b00000, 0, 0, 0, 0, 0, 1, 0, 5'b00111, 5'b00000, 0);
        tab[22] = mk(5'b00000, 0, 1, 0, 1, 1, 1, 1, 5'b00000, 5'b11111, 0); // exc+csr+v_done
        tab[23] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00111, 0);
        tab[24] = mk(5'b01000, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 5'b00111, 0);
        tab[25] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0); // back to run
        tab[26] = mk(5'b00000, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b11111, 0); // exception
        tab[27] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00111, 0);
        tab[28] = mk(5'b00000, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b11111, 0); // reload
        tab[29] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00111, 0);
        tab[30] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00111, 0);
        tab[31] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);

        // Reset held: busy inputs must not leak through as stalls.
        vi = '0;
        vi.busy = 5'b11111;
        drive(vi);
        #3;
        $display("reset t=%0t stall=%b flush=%b vdd=%b", $time, d_stall, d_flush, v_decode_done);
        chk("reset", "stall", d_stall, 5'b00000);
        chk("reset", "flush", d_flush, 5'b11111);
        chk("reset", "v_decode_done", {4'b0, v_decode_done}, 5'b00000);
        @(negedge CLK);
        vi = '0;
        drive(vi);
        RST = 1'b0;
        model_reset();

        // Directed table.
        for (int t = 0; t < 32; t++) do_cycle(tab[t].in, 1'b1, tab[t], $sformatf("tab%0d", t));

        // Reset in the middle of a vector, with v_done pending.
        vi = '0; vi.dec_ena = 1'b1; vi.vbusy = 1'b1;
        do_cycle(vi, 1'b0, none, "rstvec");
        vi = '0; vi.vbusy = 1'b1;
        do_cycle(vi, 1'b0, none, "rstvec");
        @(negedge CLK);
        vi = '0; vi.vbusy = 1'b1; vi.vdone = 1'b1; vi.busy = 5'b01000;
        drive(vi);
        #2 RST = 1'b1;
        #1;
        $display("rstvec t=%0t stall=%b flush=%b vdd=%b", $time, d_stall, d_flush, v_decode_done);
        chk("rstvec_async", "stall", d_stall, 5'b00000);
        chk("rstvec_async", "flush", d_flush, 5'b11111);
        chk("rstvec_async", "v_decode_done", {4'b0, v_decode_done}, 5'b00000);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        vi = '0;
        do_cycle(vi, 1'b1, mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0), "rstvec_after");
        vi = '0; vi.vdone = 1'b1;
        do_cycle(vi, 1'b1, mk(5'b00000, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 0), "rstvec_run");
        vi = '0;
        do_cycle(vi, 1'b1, mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0), "rstvec_nopulse");

`ifdef RV32V_HAZARD_WDOG_EN
        // Watchdog: vector never completes; expiry on the WD-th busy cycle.
        begin
            int fire_at;
            fire_at = 0;
            vi = '0; vi.dec_ena = 1'b1; vi.vbusy = 1'b1;
            do_cycle(vi, 1'b0, none, "wdog");
            vi = '0; vi.vbusy = 1'b1;
            for (int k = 1; k <= WD + 3; k++) begin
                do_cycle(vi, 1'b0, none, "wdog");
                if (last_fire && fire_at == 0) fire_at = k;
            end
            chk("wdog", "fire_cycle", 5'(fire_at), 5'(WD));
        end
`endif

        // Randomized phase against the model.
        for (int r = 0; r < 600; r++) begin
            vi = '0;
            for (int k = 0; k < 5; k++) vi.busy[k] = ($urandom_range(3) == 0);
            vi.dec_ena = ($urandom_range(1) == 1);
            vi.ex_ena  = ($urandom_range(1) == 1);
            vi.mem_ena = ($urandom_range(1) == 1);
            vi.wb_ena  = ($urandom_range(2) == 0);
            vi.csr     = ((m_mode == 0) || (m_mode == 2)) && ($urandom_range(5) == 0);
            vi.exc     = ($urandom_range(15) == 0);
            vi.vbusy   = ($urandom_range(1) == 1);
            vi.vdone   = ($urandom_range(3) == 0);
            do_cycle(vi, 1'b0, none, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rv32v_hazard_unit.md
Name: rv32v_hazard_unit

Overview:
Central stall/flush controller for the RV32V vector pipeline (fetch1, fetch2, decode, execute, memory, writeback). Consumes per-stage busy/valid flags, CSR-update and exception indications, and the ROB's vector-done signal. Drives per-stage stall/flush and the decode-side vector handshake (v_decode_done). Sequential control covers vector-instruction occupancy, CSR pipeline drain and multi-cycle exception flush.

Parameters:
FLUSH_CYCLES, 2, cycles front-end flush is held after an exception (1..15).
WDOG_LIMIT, 1024, vector-busy watchdog limit in cycles (used only with optional feature).

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
busy_f1, busy_f2, busy_dec, busy_ex, busy_mem  in  1 each  stage cannot accept/advance
decode_ena, execute_ena, memory_ena, writeback_ena  in  1 each  stage holds a valid instruction
csr_update  in  1  memory stage commits a CSR write
exception_mem  in  1  memory stage raises an exception
v_busy  in  1  decode-stage vector latch: vector instruction in flight
v_done  in  1  ROB: all elements of current vector instruction retired
stall_f1, stall_f2, stall_dec, stall_ex, stall_mem  out  1 each  hold stage
flush_f1, flush_f2, flush_dec, flush_ex, flush_mem  out  1 each  squash stage
v_decode_done  out  1  one-cycle pulse: decode may release vector latch

Behaviour:
- States: RUN, VEC_BUSY, CSR_DRAIN, EXC_FLUSH. Reset -> RUN; flush counter 0; v_decode_done register 0.
- While RST high: all flush_* = 1, all stall_* = 0, v_decode_done = 0.
- Backpressure chain, every state, combinational: stall_mem = busy_mem; stall_ex = stall_mem | busy_ex; stall_dec = stall_ex | busy_dec; stall_f2 = stall_dec | busy_f2; stall_f1 = stall_f2 | busy_f1. State terms below are ORed in.
- Event priority, same cycle: exception_mem > csr_update (qualified by memory_ena) > v_busy/v_done.
- RUN: decode_ena & v_busy -> VEC_BUSY.
- RUN: csr_update & memory_ena -> same-cycle flush_f1, flush_f2, flush_dec, flush_ex; next CSR_DRAIN.
- VEC_BUSY: stall_f1, stall_f2, stall_dec forced 1; ex/mem advance normally.
- VEC_BUSY: v_done -> RUN; v_decode_done registered high for exactly the following cycle. A v_done outside VEC_BUSY is ignored (no pulse).
- CSR_DRAIN: stall_f1, stall_f2 forced 1; flush_dec forced 1.
- CSR_DRAIN exit: busy_ex=0 & busy_mem=0 & writeback_ena=0 -> RUN. A second csr_update is impossible here (flushed); ignore it.
- Any state: exception_mem -> same-cycle flush on all five stages. Load counter with FLUSH_CYCLES-1; next EXC_FLUSH. A pending VEC_BUSY or CSR_DRAIN is abandoned; no v_decode_done pulse.
- EXC_FLUSH: flush_f1, flush_f2, flush_dec forced 1; counter decrements; count 0 -> RUN.
- EXC_FLUSH: a new exception_mem reloads the counter.
- FLUSH_CYCLES=1: EXC_FLUSH lasts exactly one cycle.
- Flush overrides stall: a stage with flush_x=1 also sees stall_x=0.

Optional Feature:
RV32V_HAZARD_WDOG_EN.
- Defined: counter of at least clog2(WDOG_LIMIT+1) bits, cleared on entering VEC_BUSY, increments each VEC_BUSY cycle. Reaching WDOG_LIMIT is treated exactly as exception_mem (all-stage flush, EXC_FLUSH). Extra output wdog_fire pulses one cycle.
- Undefined: no counter, no wdog_fire port; VEC_BUSY waits indefinitely for v_done.

Decomposition:
- Shared package rv32v_pkg holds hazard_state_t enum (RUN, VEC_BUSY, CSR_DRAIN, EXC_FLUSH) and the FLUSH_CNT_W width constant.
- One natural sub-module, rv32v_flush_counter: loadable down-counter with zero flag, reused for EXC_FLUSH and the watchdog.

Test Plan:
- Reset mid-VEC_BUSY: assert RST during VEC_BUSY -> all flush_*=1 immediately. After release: state RUN, stalls 0, no v_decode_done pulse.
- Vector stall: decode_ena=1, v_busy=1 at cycle 0; v_done at cycle 5 -> stall_f1/f2/dec high cycles 1-5, low at cycle 6; v_decode_done high only at cycle 6.
- CSR drain: csr_update=1, memory_ena=1, busy_mem=1 for 3 further cycles -> flush_f1..flush_ex high cycle 0. Then stall_f1/f2 and flush_dec held until busy_mem, busy_ex and writeback_ena are all 0; RUN the cycle after.
- Exception priority: exception_mem, csr_update and v_done together in VEC_BUSY, FLUSH_CYCLES=3 -> all five flushes that cycle, then f1/f2/dec flushed 2 more cycles, no v_decode_done pulse.
- Backpressure chain: busy_ex=1 only -> stall_ex, stall_dec, stall_f2, stall_f1 = 1, stall_mem = 0.
- Watchdog (macro on, WDOG_LIMIT=8): VEC_BUSY with no v_done -> wdog_fire and all flushes on the 8th busy cycle, then EXC_FLUSH.
